comp_32_seq: RTL



---
 rtl/comp_32_seq.sv | 72 +++++++
 1 files changed

// File: rtl/comp_32_seq.sv
// comp_32_seq: multicycle unsigned comparator scanning SLICE bits per clock from the MSB end.
// Define COMP_EARLY_EXIT_EN to leave the scan on the first differing slice.
module comp_32_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic             eq_out,
  output logic             gt_out
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CW-1:0] cnt;
  logic diff_found, gt_flag;
  logic [SLICE-1:0] sa, sb;
  logic d, g, last;
  // the first difference wins; later slices cannot overwrite the verdict
  always_comb begin
    sa = a_sh[WIDTH-1 -: SLICE];
    sb = b_sh[WIDTH-1 -: SLICE];
    d = diff_found | (sa != sb);
    g = diff_found ? gt_flag : (sa > sb);
`ifdef COMP_EARLY_EXIT_EN
    last = (cnt == '0) || d;
`else
    last = (cnt == '0);
`endif
  end
  assign busy = state == SCAN;
  assign done = state == DONE;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      a_sh <= '0;
      b_sh <= '0;
      cnt <= '0;
      diff_found <= 1'b0;
      gt_flag <= 1'b0;
      eq_out <= 1'b0;
      gt_out <= 1'b0;
    end else if (state == IDLE && start) begin
      a_sh <= in1;
      b_sh <= in2;
      cnt <= CW'(NSLICE - 1);
      diff_found <= 1'b0;
      gt_flag <= 1'b0;
      state <= SCAN;
    end else if (state == SCAN) begin
      a_sh <= a_sh << SLICE;
      b_sh <= b_sh << SLICE;
      cnt <= cnt - 1'b1;
      diff_found <= d;
      gt_flag <= g;
      if (last) begin
        eq_out <= ~d;
        gt_out <= d & g;
        state <= DONE;
      end
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
endmodule
